// File: rtl/pipeline_hazard_controller.sv
// Purpose : stall/flush sequencer for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) with perf counters.
// Latency : control outputs are combinational from state and inputs; the FSM and counters update on the next CLK edge.
// Backpressure: DMEM busy freezes every stage; IMEM busy stalls fetch; taken branches during a fetch wait in REDIRECT_PEND.
module pipeline_hazard_controller #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IMEM_BUSY_WAIT,
    input  logic              DMEM_BUSY_WAIT,
    input  logic [REG_AW-1:0] ID_RS1,
    input  logic [REG_AW-1:0] ID_RS2,
    input  logic              ID_USES_RS1,
    input  logic              ID_USES_RS2,
    input  logic [REG_AW-1:0] EX_RD,
    input  logic              EX_MEM_READ,
    input  logic              EX_BRANCH_TAKEN,
    input  logic [XLEN-1:0]   EX_TARGET,
    output logic              PC_WRITE_EN,
    output logic              PC_SELECT,
    output logic [XLEN-1:0]   PC_REDIRECT_ADDR,
    output logic              IF_ID_EN,
    output logic              ID_EX_EN,
    output logic              EX_MEM_EN,
    output logic              MEM_WB_EN,
    output logic              IF_ID_FLUSH,
    output logic              ID_EX_FLUSH,
    output logic [CNT_W-1:0]  STALL_CYCLES,
    output logic [CNT_W-1:0]  REDIRECTS
);

    typedef enum logic {
        RUN           = 1'b0,
        REDIRECT_PEND = 1'b1
    } state_t;

    // One bundle for every per-cycle control strobe so each priority row sets them together.
    typedef struct packed {
        logic pc_write_en;
        logic pc_select;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
    } ctl_t;

    state_t            state;
    logic [XLEN-1:0]   pend_target;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  redirect_cnt;

    ctl_t              ctl;
    logic [XLEN-1:0]   redirect_addr;
    logic              load_use;
    logic              redirect_accept;
    logic              go_pend;
    logic              pend_done;

    // Load-use: a load in EX writes a register the ID instruction actually reads (x0 never hazards).
    always_comb begin
        load_use = EX_MEM_READ && (EX_RD != '0) &&
                   ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                    (ID_USES_RS2 && (ID_RS2 == EX_RD)));
    end

    // Resolve control strobes: reset, pending redirect, then the RUN priority list.
    always_comb begin
        ctl             = '0;
        redirect_addr   = '0;
        redirect_accept = 1'b0;
        go_pend         = 1'b0;
        pend_done       = 1'b0;

        if (RESET) begin
            // Hold everything and keep bubbles flowing into IF/ID and ID/EX.
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_flush = 1'b1;
        end else if (state == REDIRECT_PEND) begin
            // Keep steering the PC at the latched target; the wrong-path fetch is discarded.
            ctl.pc_select   = 1'b1;
            redirect_addr   = pend_target;
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_flush = 1'b1;
            ctl.ex_mem_en   = !DMEM_BUSY_WAIT;
            ctl.mem_wb_en   = !DMEM_BUSY_WAIT;
            ctl.pc_write_en = !IMEM_BUSY_WAIT && !DMEM_BUSY_WAIT;
            pend_done       = ctl.pc_write_en;
        end else if (DMEM_BUSY_WAIT) begin
            // Full freeze: branch and load-use inputs persist and are re-evaluated afterwards.
            ctl = '0;
        end else if (EX_BRANCH_TAKEN) begin
            ctl.pc_select   = 1'b1;
            redirect_addr   = EX_TARGET;
            ctl.pc_write_en = !IMEM_BUSY_WAIT;
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_flush = 1'b1;
            ctl.ex_mem_en   = 1'b1;
            ctl.mem_wb_en   = 1'b1;
            redirect_accept = 1'b1;
            go_pend         = IMEM_BUSY_WAIT;
        end else if (load_use) begin
            // One bubble into EX while PC and IF/ID hold the dependent instruction.
            ctl.id_ex_flush = 1'b1;
            ctl.ex_mem_en   = 1'b1;
            ctl.mem_wb_en   = 1'b1;
        end else if (IMEM_BUSY_WAIT) begin
            // Fetch not ready: inject a bubble into IF/ID, drain the back end.
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_en    = 1'b1;
            ctl.ex_mem_en   = 1'b1;
            ctl.mem_wb_en   = 1'b1;
        end else begin
            ctl.pc_write_en = 1'b1;
            ctl.if_id_en    = 1'b1;
            ctl.id_ex_en    = 1'b1;
            ctl.ex_mem_en   = 1'b1;
            ctl.mem_wb_en   = 1'b1;
        end
    end

    // Redirect FSM: latch the target when a taken branch meets a busy fetch, release once the PC loads it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= RUN;
            pend_target <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (go_pend) begin
                        state       <= REDIRECT_PEND;
                        pend_target <= EX_TARGET;
                    end
                end
                REDIRECT_PEND: begin
                    if (pend_done) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Saturating performance counters: PC-stall cycles and accepted redirects.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (!ctl.pc_write_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect_accept && (redirect_cnt != '1)) begin
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            end
        end
    end

    // Drive the ports from the resolved control bundle and counters.
    always_comb begin
        PC_WRITE_EN      = ctl.pc_write_en;
        PC_SELECT        = ctl.pc_select;
        PC_REDIRECT_ADDR = redirect_addr;
        IF_ID_EN         = ctl.if_id_en;
        ID_EX_EN         = ctl.id_ex_en;
        EX_MEM_EN        = ctl.ex_mem_en;
        MEM_WB_EN        = ctl.mem_wb_en;
        IF_ID_FLUSH      = ctl.if_id_flush;
        ID_EX_FLUSH      = ctl.id_ex_flush;
        STALL_CYCLES     = stall_cnt;
        REDIRECTS        = redirect_cnt;
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Purpose : directed, table-driven checks of the hazard controller with a 4-bit counter build.
// Latency : inputs change on the falling edge; combinational outputs and counters are sampled 1 time unit later.
// Backpressure: exercised through IMEM/DMEM busy stimulus only.
module tb_pipeline_hazard_controller;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    // Control word order: pc_we, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl
    localparam logic [7:0] C_IDLE   = 8'b1011_1100;
    localparam logic [7:0] C_LU     = 8'b0000_1101;
    localparam logic [7:0] C_BR     = 8'b1100_1111;
    localparam logic [7:0] C_BRWAIT = 8'b0100_1111;
    localparam logic [7:0] C_IMEM   = 8'b0001_1110;
    localparam logic [7:0] C_FREEZE = 8'b0000_0000;
    localparam logic [7:0] C_RESET  = 8'b0000_0011;
    localparam logic [7:0] C_PEND_D = 8'b0100_0011;

    logic              CLK;
    logic              RESET;
    logic              IMEM_BUSY_WAIT;
    logic              DMEM_BUSY_WAIT;
    logic [REG_AW-1:0] ID_RS1;
    logic [REG_AW-1:0] ID_RS2;
    logic              ID_USES_RS1;
    logic              ID_USES_RS2;
    logic [REG_AW-1:0] EX_RD;
    logic              EX_MEM_READ;
    logic              EX_BRANCH_TAKEN;
    logic [XLEN-1:0]   EX_TARGET;
    logic              PC_WRITE_EN;
    logic              PC_SELECT;
    logic [XLEN-1:0]   PC_REDIRECT_ADDR;
    logic              IF_ID_EN;
    logic              ID_EX_EN;
    logic              EX_MEM_EN;
    logic              MEM_WB_EN;
    logic              IF_ID_FLUSH;
    logic              ID_EX_FLUSH;
    logic [CNT_W-1:0]  STALL_CYCLES;
    logic [CNT_W-1:0]  REDIRECTS;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_controller #(
        .XLEN  (XLEN),
        .REG_AW(REG_AW),
        .CNT_W (CNT_W)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .IMEM_BUSY_WAIT  (IMEM_BUSY_WAIT),
        .DMEM_BUSY_WAIT  (DMEM_BUSY_WAIT),
        .ID_RS1          (ID_RS1),
        .ID_RS2          (ID_RS2),
        .ID_USES_RS1     (ID_USES_RS1),
        .ID_USES_RS2     (ID_USES_RS2),
        .EX_RD           (EX_RD),
        .EX_MEM_READ     (EX_MEM_READ),
        .EX_BRANCH_TAKEN (EX_BRANCH_TAKEN),
        .EX_TARGET       (EX_TARGET),
        .PC_WRITE_EN     (PC_WRITE_EN),
        .PC_SELECT       (PC_SELECT),
        .PC_REDIRECT_ADDR(PC_REDIRECT_ADDR),
        .IF_ID_EN        (IF_ID_EN),
        .ID_EX_EN        (ID_EX_EN),
        .EX_MEM_EN       (EX_MEM_EN),
        .MEM_WB_EN       (MEM_WB_EN),
        .IF_ID_FLUSH     (IF_ID_FLUSH),
        .ID_EX_FLUSH     (ID_EX_FLUSH),
        .STALL_CYCLES    (STALL_CYCLES),
        .REDIRECTS       (REDIRECTS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        imem;
        logic        dmem;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        mrd;
        logic        br;
        logic [31:0] tgt;
        logic [7:0]  exp_ctl;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[11];

    task automatic drive(input logic imem, input logic dmem, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic [4:0] rd, input logic mrd, input logic br,
                         input logic [31:0] tgt);
        IMEM_BUSY_WAIT  = imem;
        DMEM_BUSY_WAIT  = dmem;
        ID_RS1          = rs1;
        ID_RS2          = rs2;
        ID_USES_RS1     = u1;
        ID_USES_RS2     = u2;
        EX_RD           = rd;
        EX_MEM_READ     = mrd;
        EX_BRANCH_TAKEN = br;
        EX_TARGET       = tgt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic check_ctl(input string nm, input logic [7:0] exp_ctl, input logic [31:0] exp_addr);
        logic [7:0] got;
        got = {PC_WRITE_EN, PC_SELECT, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_FLUSH, ID_EX_FLUSH};
        checks++;
        if (got !== exp_ctl || PC_REDIRECT_ADDR !== exp_addr) begin
            failures++;
            $display("FAIL %s: ctl=%b addr=%h, expected ctl=%b addr=%h", nm, got, PC_REDIRECT_ADDR, exp_ctl, exp_addr);
        end
    endtask

    task automatic check_cnt(input string nm, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Two reset edges, then release on a falling edge with idle inputs.
    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        idle();
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"idle",        1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0,  C_IDLE,   32'h0};
        vecs[1]  = '{"lu_rs1",      1'b0, 1'b0, 5'd7, 5'd2, 1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 32'h0,  C_LU,     32'h0};
        vecs[2]  = '{"rs2_unused",  1'b0, 1'b0, 5'd3, 5'd7, 1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 32'h0,  C_IDLE,   32'h0};
        vecs[3]  = '{"not_load",    1'b0, 1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 32'h0,  C_IDLE,   32'h0};
        vecs[4]  = '{"br_beats_lu", 1'b0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7,  1'b1, 1'b1, 32'h44, C_BR,     32'h44};
        vecs[5]  = '{"dmem_lu",     1'b0, 1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 32'h0,  C_FREEZE, 32'h0};
        vecs[6]  = '{"imem_only",   1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0,  C_IMEM,   32'h0};
        vecs[7]  = '{"imem_lu",     1'b1, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 32'h0,  C_LU,     32'h0};
        vecs[8]  = '{"all_busy_br", 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 32'h88, C_FREEZE, 32'h0};
        vecs[9]  = '{"lu_rs2_r31",  1'b0, 1'b0, 5'd31, 5'd31, 1'b0, 1'b1, 5'd31, 1'b1, 1'b0, 32'h0, C_LU,     32'h0};
        vecs[10] = '{"lu_x0",       1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 32'h0,  C_IDLE,   32'h0};

        // Reset: held for two edges, then released.
        RESET = 1'b1;
        idle();
        @(negedge CLK); #1;
        check_ctl("reset_c1", C_RESET, 32'h0);
        check_cnt("reset_stall", STALL_CYCLES, 4'd0);
        check_cnt("reset_redir", REDIRECTS, 4'd0);
        @(negedge CLK); #1;
        check_ctl("reset_c2", C_RESET, 32'h0);
        RESET = 1'b0;
        #1;
        check_ctl("post_reset", C_IDLE, 32'h0);

        // Load-use on rs2: one bubble.
        @(negedge CLK);
        drive(1'b0, 1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 32'h0);
        #1; check_ctl("lu_stall", C_LU, 32'h0);
        @(negedge CLK);
        idle();
        #1; check_ctl("lu_after", C_IDLE, 32'h0);
        check_cnt("lu_stall_cnt", STALL_CYCLES, 4'd1);
        @(negedge CLK);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 32'h0);
        #1; check_ctl("lu_rd0", C_IDLE, 32'h0);
        @(negedge CLK);
        idle();
        #1; check_cnt("lu_rd0_cnt", STALL_CYCLES, 4'd1);

        // Taken branch, no busy.
        @(negedge CLK);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h100);
        #1; check_ctl("br_now", C_BR, 32'h100);
        @(negedge CLK);
        idle();
        #1; check_cnt("br_redir", REDIRECTS, 4'd1);
        check_cnt("br_stall", STALL_CYCLES, 4'd1);

        // Taken branch during fetch: IMEM busy for 3 cycles, target held.
        @(negedge CLK);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h200);
        #1; check_ctl("pend_enter", C_BRWAIT, 32'h200);
        @(negedge CLK);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h999);
        #1; check_ctl("pend_c2", C_BRWAIT, 32'h200);
        check_cnt("pend_redir", REDIRECTS, 4'd2);
        @(negedge CLK);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        #1; check_ctl("pend_c3", C_BRWAIT, 32'h200);
        @(negedge CLK);
        idle();
        #1; check_ctl("pend_release", C_BR, 32'h200);
        check_cnt("pend_stall", STALL_CYCLES, 4'd4);
        @(negedge CLK);
        #1; check_ctl("pend_run", C_IDLE, 32'h0);
        check_cnt("pend_redir2", REDIRECTS, 4'd2);

        // DMEM freeze over a taken branch for 4 cycles, then the redirect.
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h300);
            #1; check_ctl($sformatf("freeze_%0d", i), C_FREEZE, 32'h0);
        end
        @(negedge CLK);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h300);
        #1; check_ctl("freeze_release", C_BR, 32'h300);
        check_cnt("freeze_stall", STALL_CYCLES, 4'd8);
        @(negedge CLK);
        idle();
        #1; check_cnt("freeze_redir", REDIRECTS, 4'd3);

        // Pending redirect blocked by DMEM busy after IMEM clears.
        @(negedge CLK);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h400);
        #1; check_ctl("pd_enter", C_BRWAIT, 32'h400);
        @(negedge CLK);
        drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        #1; check_ctl("pd_dmem", C_PEND_D, 32'h400);
        @(negedge CLK);
        idle();
        #1; check_ctl("pd_release", C_BR, 32'h400);
        @(negedge CLK);
        #1; check_ctl("pd_run", C_IDLE, 32'h0);
        check_cnt("pd_stall", STALL_CYCLES, 4'd10);
        check_cnt("pd_redir", REDIRECTS, 4'd4);

        // Single-cycle priority table (all rows stay in RUN).
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            drive(vecs[i].imem, vecs[i].dmem, vecs[i].rs1, vecs[i].rs2, vecs[i].u1,
                  vecs[i].u2, vecs[i].rd, vecs[i].mrd, vecs[i].br, vecs[i].tgt);
            #1; check_ctl(vecs[i].name, vecs[i].exp_ctl, vecs[i].exp_addr);
        end

        // Reset while REDIRECT_PEND discards the latched target.
        do_reset();
        @(negedge CLK);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h500);
        #1; check_ctl("rp_enter", C_BRWAIT, 32'h500);
        @(negedge CLK);
        RESET = 1'b1;
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        #1; check_ctl("rp_reset", C_RESET, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        idle();
        #1; check_ctl("rp_after", C_IDLE, 32'h0);
        check_cnt("rp_redir", REDIRECTS, 4'd0);

        // Stall counter saturation with IMEM busy for 20 cycles.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
            #1; check_cnt($sformatf("sat_stall_%0d", i), STALL_CYCLES, (i > 15) ? 4'd15 : 4'(i));
        end
        @(negedge CLK);
        idle();
        #1; check_cnt("sat_stall_end", STALL_CYCLES, 4'd15);

        // Redirect counter saturation with back-to-back taken branches.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h600);
        end
        @(negedge CLK);
        idle();
        #1; check_cnt("sat_redir", REDIRECTS, 4'd15);
        check_cnt("sat_redir_stall", STALL_CYCLES, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the PC write enable, the PC redirect mux, and per-register enable and flush strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Its inputs are instruction-memory and data-memory busy-wait, load-use operand information and EX-stage branch resolution. A small FSM holds a taken-branch redirect while an instruction fetch is still outstanding. Saturating performance counters record stall cycles and redirects.

## Interface
- XLEN, 32, PC/target width
- REG_AW, 5, register-address width
- CNT_W, 16, performance-counter width

- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  synchronous, active-high reset
- IMEM_BUSY_WAIT  in  1  instruction fetch outstanding
- DMEM_BUSY_WAIT  in  1  data access outstanding
- ID_RS1, ID_RS2  in  REG_AW  source registers of the instruction in ID
- ID_USES_RS1, ID_USES_RS2  in  1  source actually read
- EX_RD  in  REG_AW  destination of the instruction in EX
- EX_MEM_READ  in  1  instruction in EX is a load
- EX_BRANCH_TAKEN  in  1  branch/jump in EX resolved taken
- EX_TARGET  in  XLEN  resolved target
- PC_WRITE_EN  out  1  PC register load enable
- PC_SELECT  out  1  1 = PC loads PC_REDIRECT_ADDR; 0 = PC+4
- PC_REDIRECT_ADDR  out  XLEN  redirect target
- IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN  out  1  pipeline register load enables
- IF_ID_FLUSH, ID_EX_FLUSH  out  1  load bubble (all-zero) on next edge; flush overrides enable
- STALL_CYCLES  out  CNT_W  cycles with PC_WRITE_EN=0, saturating
- REDIRECTS  out  CNT_W  accepted redirects, saturating

## Operation
- The FSM has two states.
  - RUN: normal operation.
  - REDIRECT_PEND: holds a latched target (XLEN bits) while a fetch is outstanding.
- Load-use hazard (LU) is true when all of the following hold:
  - EX_MEM_READ = 1
  - EX_RD ≠ 0
  - (ID_USES_RS1 and ID_RS1 = EX_RD) or (ID_USES_RS2 and ID_RS2 = EX_RD)
- Outputs are combinational from the current state and inputs. In RUN they are resolved in priority order; the first matching row applies.
  1. DMEM_BUSY_WAIT (freeze): every enable = 0, every flush = 0, PC_WRITE_EN = 0. Branch and LU inputs are ignored because they persist.
  2. EX_BRANCH_TAKEN with IMEM_BUSY_WAIT = 0: PC_SELECT = 1, PC_REDIRECT_ADDR = EX_TARGET, PC_WRITE_EN = 1, IF_ID_FLUSH = ID_EX_FLUSH = 1, EX_MEM_EN = MEM_WB_EN = 1. REDIRECTS increments.
  3. EX_BRANCH_TAKEN with IMEM_BUSY_WAIT = 1: latch EX_TARGET and go to REDIRECT_PEND. Same flushes and enables as row 2, except PC_WRITE_EN = 0. REDIRECTS increments.
  4. LU: PC_WRITE_EN = 0, IF_ID_EN = 0, ID_EX_FLUSH = 1, EX_MEM_EN = MEM_WB_EN = 1.
  5. IMEM_BUSY_WAIT: PC_WRITE_EN = 0, IF_ID_FLUSH = 1, ID_EX_EN = EX_MEM_EN = MEM_WB_EN = 1.
  6. Otherwise: all enables = 1, PC_SELECT = 0, no flush.
- REDIRECT_PEND:
  - PC_SELECT = 1 and PC_REDIRECT_ADDR = latched target throughout.
  - IF_ID_FLUSH = ID_EX_FLUSH = 1, so the wrong-path fetch is discarded.
  - EX_MEM_EN = MEM_WB_EN = !DMEM_BUSY_WAIT.
  - PC_WRITE_EN = !IMEM_BUSY_WAIT && !DMEM_BUSY_WAIT. When it is 1, return to RUN.
  - A new EX_BRANCH_TAKEN is ignored, because EX holds a bubble.
- Counters:
  - STALL_CYCLES increments on every non-reset cycle with PC_WRITE_EN = 0.
  - Both counters hold at 2^CNT_W−1 once reached.

## Timing
- RESET is sampled at posedge. The following edge yields state = RUN, latched target = 0 and both counters = 0.
- While RESET = 1, outputs are forced: all enables 0, IF_ID_FLUSH = ID_EX_FLUSH = 1, PC_WRITE_EN = 0, PC_SELECT = 0, PC_REDIRECT_ADDR = 0.
- Reset asserted in REDIRECT_PEND discards the pending redirect.
- Taken branch with no busy: the target is fetched in the next cycle, giving a penalty of exactly 2 bubbles.
- Load-use: exactly 1 bubble. On the next cycle the load is in MEM, LU is false and forwarding covers the dependence.
- Pending redirect: the PC loads the target on the first edge where both busy signals are low. The state is RUN on the following cycle.
- Simultaneous events:
  - Branch and LU together: the branch wins and no LU stall occurs.
  - DMEM busy together with any other event: freeze, and the event is re-evaluated once DMEM busy falls.

## Test plan
- Reset:
  - Stimulus: RESET = 1 for 2 cycles, then release.
  - Required while RESET = 1: PC_WRITE_EN = 0, both flushes = 1, counters = 0.
  - Required first cycle after release (no events): all enables = 1.
- Load-use:
  - Stimulus: EX_MEM_READ = 1, EX_RD = 5, ID_RS2 = 5, ID_USES_RS2 = 1.
  - Required: one cycle of PC_WRITE_EN = 0, IF_ID_EN = 0, ID_EX_FLUSH = 1; STALL_CYCLES = 1.
  - Stimulus: repeat with EX_RD = 0. Required: no stall.
- Taken branch, no busy:
  - Stimulus: EX_BRANCH_TAKEN = 1, EX_TARGET = 0x0000_0100.
  - Required same cycle: PC_SELECT = 1, PC_REDIRECT_ADDR = 0x100, both flushes = 1.
  - Required: REDIRECTS = 1.
- Taken branch during fetch:
  - Stimulus: EX_BRANCH_TAKEN = 1 and EX_TARGET = 0x200 with IMEM_BUSY_WAIT = 1 for 3 cycles.
  - Required: REDIRECT_PEND held for 3 cycles with PC_REDIRECT_ADDR = 0x200 and PC_WRITE_EN = 0.
  - Required on the 4th cycle: PC_WRITE_EN = 1, then RUN.
- DMEM freeze:
  - Stimulus: DMEM_BUSY_WAIT = 1 for 4 cycles while EX_BRANCH_TAKEN = 1.
  - Required during freeze: all enables and flushes = 0.
  - Required on the cycle DMEM busy drops: the redirect happens.
- Saturation:
  - Stimulus: CNT_W = 4, hold IMEM_BUSY_WAIT = 1 for 20 cycles.
  - Required: STALL_CYCLES stops at 15.
